// File: rtl/intersection_pkg.sv
// intersection_pkg: shared definitions for the two-road intersection scheduler.
//   - phase_e   : phase state encoding (NS_G..AR2, plus FLASH used only when
//                 the TLS_FLASH_EN build option is enabled)
//   - GYR_*     : one-hot {G,Y,R} head codes
//   - DEF_*_DUR : reset values of the programmable durations
//   - helpers   : per-road head decode and the normal phase successor
package intersection_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } phase_e;

  localparam logic [2:0] GYR_G   = 3'b100;
  localparam logic [2:0] GYR_Y   = 3'b010;
  localparam logic [2:0] GYR_R   = 3'b001;
  localparam logic [2:0] GYR_OFF = 3'b000;

  localparam int DEF_G_DUR  = 4;
  localparam int DEF_Y_DUR  = 2;
  localparam int DEF_AR_DUR = 1;
  localparam int MIN_G_DUR  = 2;

  // NS head lamp for a non-flash phase.
  function automatic logic [2:0] ns_head(input phase_e p);
    logic [2:0] h;
    case (p)
      NS_G:    h = GYR_G;
      NS_Y:    h = GYR_Y;
      default: h = GYR_R;
    endcase
    return h;
  endfunction

  // EW head lamp for a non-flash phase.
  function automatic logic [2:0] ew_head(input phase_e p);
    logic [2:0] h;
    case (p)
      EW_G:    h = GYR_G;
      EW_Y:    h = GYR_Y;
      default: h = GYR_R;
    endcase
    return h;
  endfunction

  // Normal ring order; anything unexpected recovers to NS_G.
  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    case (p)
      NS_G:    n = NS_Y;
      NS_Y:    n = AR1;
      AR1:     n = EW_G;
      EW_G:    n = EW_Y;
      EW_Y:    n = AR2;
      AR2:     n = NS_G;
      default: n = NS_G;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// phase_timer: the single shared phase counter.
//   clk, reset : clock and asynchronous active-low reset (cnt resets to 1)
//   clear      : load 1 (phase entry); overrides freeze
//   freeze     : hold the count
//   dur        : duration of the current phase; 0 behaves as 1
//   cnt        : current count, 1-based within the phase
//   expire     : cnt has reached the (clamped) duration
module phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          freeze,
  input  logic [TW-1:0] dur,
  output logic [TW-1:0] cnt,
  output logic          expire
);

  logic [TW-1:0] cnt_r;
  logic [TW-1:0] dur_eff_s;

  // Zero-duration clamp and expiry compare.
  always_comb begin
    if (dur == {TW{1'b0}}) begin
      dur_eff_s = {{(TW-1){1'b0}}, 1'b1};
    end else begin
      dur_eff_s = dur;
    end
    expire = (cnt_r == dur_eff_s);
  end

  // Counter: restart at 1 on phase entry, otherwise count unless frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {{(TW-1){1'b0}}, 1'b1};
    end else if (clear) begin
      cnt_r <= {{(TW-1){1'b0}}, 1'b1};
    end else if (!freeze) begin
      cnt_r <= cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: sequences the NS and EW heads through
// green / yellow / all-red, with pedestrian requests and emergency preempt.
//   clk, reset          : clock, asynchronous active-low reset
//   Set                 : capture Gns/Gew/Yin/ARin and restart at NS_G
//   Stop                : freeze phase and counter
//   Jump                : end the current green early (emergency)
//   Gns, Gew, Yin, ARin : phase durations
//   ped_ns, ped_ew      : crosswalk buttons
//   flash               : (TLS_FLASH_EN only) flashing-yellow override
//   ns_gyr, ew_gyr      : one-hot {G,Y,R} head outputs
//   walk_ns, walk_ew    : walk lamps
//   phase               : current state code
// Build option: define TLS_FLASH_EN to add the flash input and FLASH state.
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int TW     = 4,
  parameter int DEF_G  = DEF_G_DUR,
  parameter int DEF_Y  = DEF_Y_DUR,
  parameter int DEF_AR = DEF_AR_DUR,
  parameter int MIN_G  = MIN_G_DUR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Set,
  input  logic          Stop,
  input  logic          Jump,
  input  logic [TW-1:0] Gns,
  input  logic [TW-1:0] Gew,
  input  logic [TW-1:0] Yin,
  input  logic [TW-1:0] ARin,
  input  logic          ped_ns,
  input  logic          ped_ew,
`ifdef TLS_FLASH_EN
  input  logic          flash,
`endif
  output logic [2:0]    ns_gyr,
  output logic [2:0]    ew_gyr,
  output logic          walk_ns,
  output logic          walk_ew,
  output logic [2:0]    phase
);

  phase_e        state_r, state_s;
  logic [TW-1:0] g_ns_r, g_ew_r, y_r, ar_r;
  logic [TW-1:0] dur_s, cnt_s;
  logic          clear_s, expire_s, trunc_s;
  logic          p_ns_r, p_ew_r, walk_ns_r, walk_ew_r;
  logic [2:0]    ns_gyr_r, ew_gyr_r;
  logic          enter_ns_s, leave_ns_s, enter_ew_s, leave_ew_s;

  phase_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_s),
    .freeze (Stop),
    .dur    (dur_s),
    .cnt    (cnt_s),
    .expire (expire_s)
  );

  // Programmed durations: defaults on reset, captured on Set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_ns_r <= TW'(DEF_G);
      g_ew_r <= TW'(DEF_G);
      y_r    <= TW'(DEF_Y);
      ar_r   <= TW'(DEF_AR);
    end else if (Set) begin
      g_ns_r <= Gns;
      g_ew_r <= Gew;
      y_r    <= Yin;
      ar_r   <= ARin;
    end else begin
      g_ns_r <= g_ns_r;
      g_ew_r <= g_ew_r;
      y_r    <= y_r;
      ar_r   <= ar_r;
    end
  end

  // Duration of the current phase and pedestrian truncation of a green.
  always_comb begin
    case (state_r)
      NS_G:       dur_s = g_ns_r;
      EW_G:       dur_s = g_ew_r;
      NS_Y, EW_Y: dur_s = y_r;
      default:    dur_s = ar_r;
    endcase
    if (state_r == NS_G) begin
      trunc_s = p_ew_r && (cnt_s >= TW'(MIN_G));
    end else if (state_r == EW_G) begin
      trunc_s = p_ns_r && (cnt_s >= TW'(MIN_G));
    end else begin
      trunc_s = 1'b0;
    end
  end

  // Next state, in priority order Set > flash > Jump > Stop > expiry.
  always_comb begin
    state_s = state_r;
    clear_s = 1'b0;
    if (Set) begin
      state_s = NS_G;
      clear_s = 1'b1;
`ifdef TLS_FLASH_EN
    end else if (flash) begin
      state_s = FLASH;
      clear_s = (state_r != FLASH);
    end else if (state_r == FLASH) begin
      state_s = AR2;
      clear_s = 1'b1;
`endif
    end else if (Jump && (state_r == NS_G)) begin
      state_s = NS_Y;
      clear_s = 1'b1;
    end else if (Jump && (state_r == EW_G)) begin
      state_s = EW_Y;
      clear_s = 1'b1;
    end else if (Stop) begin
      state_s = state_r;
    end else if (expire_s || trunc_s) begin
      state_s = next_phase(state_r);
      clear_s = 1'b1;
    end else begin
      state_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= NS_G;
    end else begin
      state_r <= state_s;
    end
  end

  assign enter_ns_s = (state_s == NS_G) && (state_r != NS_G);
  assign leave_ns_s = (state_s != NS_G) && (state_r == NS_G);
  assign enter_ew_s = (state_s == EW_G) && (state_r != EW_G);
  assign leave_ew_s = (state_s != EW_G) && (state_r == EW_G);

  // Pedestrian latches and walk lamps. A latched request is served on green
  // entry; a press while the walk lamp is lit is absorbed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_ns_r    <= 1'b0;
      p_ew_r    <= 1'b0;
      walk_ns_r <= 1'b0;
      walk_ew_r <= 1'b0;
    end else if (Set) begin
      p_ns_r    <= 1'b0;
      p_ew_r    <= 1'b0;
      walk_ns_r <= 1'b0;
      walk_ew_r <= 1'b0;
    end else begin
      if (enter_ns_s) begin
        walk_ns_r <= p_ns_r;
        p_ns_r    <= ped_ns & ~p_ns_r;
      end else begin
        walk_ns_r <= leave_ns_s ? 1'b0 : walk_ns_r;
        p_ns_r    <= (state_r == NS_G && walk_ns_r) ? p_ns_r : (p_ns_r | ped_ns);
      end
      if (enter_ew_s) begin
        walk_ew_r <= p_ew_r;
        p_ew_r    <= ped_ew & ~p_ew_r;
      end else begin
        walk_ew_r <= leave_ew_s ? 1'b0 : walk_ew_r;
        p_ew_r    <= (state_r == EW_G && walk_ew_r) ? p_ew_r : (p_ew_r | ped_ew);
      end
    end
  end

  // Head outputs, registered from the next state so they track state_r
  // exactly. In FLASH the yellow toggles off its own previous value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ns_gyr_r <= GYR_G;
      ew_gyr_r <= GYR_R;
`ifdef TLS_FLASH_EN
    end else if (state_s == FLASH) begin
      ns_gyr_r <= (state_r == FLASH && ns_gyr_r[1]) ? GYR_OFF : GYR_Y;
      ew_gyr_r <= (state_r == FLASH && ns_gyr_r[1]) ? GYR_OFF : GYR_Y;
`endif
    end else begin
      ns_gyr_r <= ns_head(state_s);
      ew_gyr_r <= ew_head(state_s);
    end
  end

  assign ns_gyr  = ns_gyr_r;
  assign ew_gyr  = ew_gyr_r;
  assign walk_ns = walk_ns_r;
  assign walk_ew = walk_ew_r;
  assign phase   = state_r;

endmodule
